// File: rtl/adam_aes_key_schedule.sv
// AES key expansion (FIPS-197) for 128/192/256-bit keys, one word per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   key        cipher key, MSB-aligned (key[255:224] is w[0])
//   keylen     00=AES-128, 01=AES-192, 10=AES-256, 11=reserved
//   init       single-cycle start; key/keylen sampled on the accepting edge
//   round_keys round_keys[r] = {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//   nr         round count of the last valid init (0 after reset/illegal init)
//   busy       expansion in progress
//   ready      all round keys for nr are valid
//   err        sticky: last accepted init had an illegal keylen

// FIPS-197 forward S-box, purely combinational.
module adam_aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0x00 occupies the top byte lane, so entry a sits at bit 8*(255-a) = {~a, 3'b000}.
  assign y = SBOX[{~a, 3'b000} +: 8];
endmodule

module adam_aes_key_schedule #(
  parameter int unsigned MAX_ROUNDS = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [255:0]                key,
  input  logic [1:0]                  keylen,
  input  logic                        init,
  output logic [MAX_ROUNDS:0][127:0]  round_keys,
  output logic [3:0]                  nr,
  output logic                        busy,
  output logic                        ready,
  output logic                        err
);
  localparam int unsigned NW = 4 * (MAX_ROUNDS + 1);
  localparam int unsigned IW = $clog2(NW);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t             state;
  logic [NW-1:0][31:0] w;
  logic [IW-1:0]      i;
  logic [3:0]         nk;
  // pos and rc track i mod Nk and i / Nk incrementally, avoiding a divider.
  logic [2:0]         pos;
  logic [3:0]         rc;

  logic [3:0]  nk_in, nr_in;
  logic        bad_in;
  logic [31:0] temp, prev, sub_in, sub_out, f_out;
  logic [7:0]  rcon;

  always_comb begin
    nk_in  = 4'd4 + {1'b0, keylen, 1'b0};
    nr_in  = 4'd10 + {1'b0, keylen, 1'b0};
    bad_in = (keylen == 2'b11) || (32'(nr_in) > MAX_ROUNDS);
  end

  always_comb begin
    temp   = w[i - IW'(1)];
    prev   = w[i - IW'(nk)];
    sub_in = (pos == 3'd0) ? {temp[23:0], temp[31:24]} : temp;
    case (rc)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
    if (pos == 3'd0)
      f_out = sub_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && pos == 3'd4)
      f_out = sub_out;
    else
      f_out = temp;
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    adam_aes_sbox u_sbox (
      .a (sub_in[8*b +: 8]),
      .y (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    for (int unsigned r = 0; r <= MAX_ROUNDS; r++)
      round_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      w     <= '0;
      i     <= '0;
      nk    <= '0;
      pos   <= '0;
      rc    <= '0;
      nr    <= '0;
      busy  <= 1'b0;
      ready <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (init) begin
            w     <= '0;
            ready <= 1'b0;
            err   <= bad_in;
            pos   <= '0;
            rc    <= 4'd1;
            if (bad_in) begin
              nr    <= '0;
              nk    <= '0;
              i     <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              for (int unsigned k = 0; k < 8; k++)
                if (k < 32'(nk_in))
                  w[k] <= key[255-32*k -: 32];
              nr    <= nr_in;
              nk    <= nk_in;
              i     <= IW'(nk_in);
              busy  <= 1'b1;
              state <= EXPAND;
            end
          end
        end
        EXPAND: begin
          w[i] <= prev ^ f_out;
          i    <= i + IW'(1);
          if ({1'b0, pos} == nk - 4'd1) begin
            pos <= '0;
            rc  <= rc + 4'd1;
          end else begin
            pos <= pos + 3'd1;
          end
          if (i == IW'({nr, 2'b11})) begin
            state <= DONE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
